// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic (B3) master. One command goes out on the bus and
// comes back as exactly one response: read data, or ERR_DATA with rsp_err when the slave never acks.
module wb_initiator #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic [7:0]  err_count,
  output logic [1:0]  state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // The offering side keeps valid and its payload steady until that edge.
  // cmd_ready is high only in IDLE; rsp_* stay frozen while rsp_ready is low.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e     state, state_nxt;
  logic [7:0] tmo_cnt;
  logic       tmo_hit;
  logic       cmd_fire;

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign tmo_hit   = (tmo_cnt == 8'(TIMEOUT - 1));
  assign wbm_stb_o = wbm_cyc_o;
  assign state_dbg = state;

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cmd_fire) state_nxt = BUS;
      BUS:  if (wbm_ack_i || tmo_hit) state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_dat   <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      err_count <= '0;
      tmo_cnt   <= '0;
    end else begin
      cmd_ready <= (state_nxt == IDLE);
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            wbm_cyc_o <= 1'b1;
            wbm_we_o  <= cmd_we;
            wbm_sel_o <= cmd_sel;
            wbm_adr_o <= cmd_adr;
            wbm_dat_o <= cmd_dat;
            tmo_cnt   <= '0;
          end
        end
        BUS: begin
          // An ack on the final allowed cycle still completes normally.
          if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_dat   <= wbm_we_o ? 32'h0 : wbm_dat_i;
          end else if (tmo_hit) begin
            wbm_cyc_o <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_dat   <= ERR_DATA;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_initiator.sv
// Self-checking bench for wb_initiator: a scripted Wishbone slave driver, an expected-response
// queue popped at each response handshake, and a saturating timeout-count model.
module tb_wb_initiator;

  localparam int unsigned TMO     = 16;
  localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;
  logic [7:0]  err_count;
  logic [1:0]  state_dbg;

  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_err_cnt = 0;
  logic [32:0] exp_q[$];

  wb_initiator #(.TIMEOUT(TMO), .ERR_DATA(ERR_VAL)) dut (
    .wb_clk_i (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .cmd_sel  (cmd_sel),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i),
    .wbm_dat_i(wbm_dat_i),
    .err_count(err_count),
    .state_dbg(state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_cmd_ready"}, cmd_ready, 1);
    chk({pfx, "_rsp_valid"}, rsp_valid, 0);
    chk({pfx, "_rsp_err"},   rsp_err,   0);
    chk({pfx, "_rsp_dat"},   rsp_dat,   0);
    chk({pfx, "_cyc"},       wbm_cyc_o, 0);
    chk({pfx, "_stb"},       wbm_stb_o, 0);
    chk({pfx, "_we"},        wbm_we_o,  0);
    chk({pfx, "_sel"},       wbm_sel_o, 0);
    chk({pfx, "_adr"},       wbm_adr_o, 0);
    chk({pfx, "_dat"},       wbm_dat_o, 0);
    chk({pfx, "_err_count"}, err_count, 0);
    chk({pfx, "_state"},     state_dbg, 0);
  endtask

  // One complete command/response; ack_at = cyc cycle carrying the ack (0 = never).
  task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int ack_at, input logic [31:0] rdata,
                        input int bp);
    int          cyc_n;
    int          exp_len;
    logic        timed_out;
    logic [32:0] exp;
    logic [32:0] held;
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    timed_out = (ack_at == 0) || (ack_at > int'(TMO));
    exp_len   = timed_out ? int'(TMO) : ack_at;
    if (timed_out) exp = {1'b1, ERR_VAL};
    else           exp = {1'b0, (we ? 32'h0 : rdata)};
    exp_q.push_back(exp);
    if (timed_out && exp_err_cnt != 255) exp_err_cnt++;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_we = ~we; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = ~sel;
    cyc_n = 0;
    for (int k = 1; k <= 40; k++) begin
      if (!wbm_cyc_o) break;
      cyc_n++;
      if (k == 1) begin
        chk("bus_adr", wbm_adr_o, adr);
        chk("bus_dat", wbm_dat_o, dat);
        chk("bus_sel", wbm_sel_o, sel);
        chk("bus_we",  wbm_we_o,  we);
        chk("bus_stb", wbm_stb_o, 1);
        chk("bus_cmd_ready", cmd_ready, 0);
      end
      wbm_ack_i = (k == ack_at);
      wbm_dat_i = (k == ack_at) ? rdata : $urandom;
      @(negedge clk);
    end
    wbm_ack_i = 1'b0;
    chk("cyc_dropped", wbm_cyc_o, 0);
    chk("cyc_len", cyc_n, exp_len);
    chk("rsp_valid_up", rsp_valid, 1);
    chk("rsp_cmd_ready", cmd_ready, 0);
    chk("adr_held", wbm_adr_o, adr);
    chk("sel_held", wbm_sel_o, sel);
    chk("err_count", err_count, exp_err_cnt);
    held = {rsp_err, rsp_dat};
    // Backpressure with a competing command and stray acks that must both be ignored
    for (int b = 0; b < bp; b++) begin
      wbm_ack_i = 1'($urandom_range(0, 1));
      cmd_valid = 1'b1;
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_hold", {rsp_err, rsp_dat}, held);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_cyc", wbm_cyc_o, 0);
    end
    wbm_ack_i = 1'b0;
    cmd_valid = 1'b0;
    if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
    else chk("rsp", {rsp_err, rsp_dat}, exp_q.pop_front());
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_cmd_ready", cmd_ready, 1);
    chk("post_cyc", wbm_cyc_o, 0);
    chk("post_err_count", err_count, exp_err_cnt);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0; wbm_ack_i = 1'b0; wbm_dat_i = '0;
    #12;
    chk_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Stray ack in IDLE must not start anything
    wbm_ack_i = 1'b1;
    @(negedge clk);
    wbm_ack_i = 1'b0;
    chk("idle_stray_cyc", wbm_cyc_o, 0);
    chk("idle_stray_rsp", rsp_valid, 0);

    do_txn(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 3, 32'h0, 0);
    do_txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, 1, 32'h1234_5678, 0);
    do_txn(1'b0, 32'h3000_0008, 32'h0, 4'hF, 0, 32'h0, 0);
    do_txn(1'b0, 32'h3000_000C, 32'h0, 4'h3, 16, 32'hCAFE_F00D, 0);
    do_txn(1'b1, 32'h3000_0010, 32'h5555_AAAA, 4'h5, 2, 32'h0, 5);
    do_txn(1'b0, 32'h3000_0014, 32'h0, 4'hC, 4, 32'h0BAD_C0DE, 5);

    for (int i = 0; i < 20; i++)
      do_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, 18), $urandom, $urandom_range(0, 3));

    for (int i = 0; i < 300; i++)
      do_txn(1'b0, 32'h3000_0100, 32'h0, 4'hF, 0, 32'h0, 0);
    chk("err_saturated", err_count, 255);

    // Reset two cycles into a bus transfer
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0020; cmd_dat = 32'h1111_2222; cmd_sel = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("pre_rst_cyc", wbm_cyc_o, 1);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    exp_err_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;

    do_txn(1'b0, 32'h3000_0024, 32'h0, 4'hF, 2, 32'h7777_8888, 1);
    do_txn(1'b0, 32'h3000_0028, 32'h0, 4'hF, 0, 32'h0, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
